// File: rtl/fa_test_pkg.sv
// ============================================================================
// Module      : fa_test_pkg
// Description : Shared types, constants and the reference sum for the
//               full-adder self-test engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fa_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } fa_state_t;

  localparam int FA_NUM_VECTORS = 8;

  // Two-bit arithmetic sum of the three adder inputs, i.e. the expected {c,s}.
  function automatic logic [1:0] fa_expected(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fa_self_test.sv
// ============================================================================
// Module      : fa_self_test
// Description : Drives all eight full-adder input vectors, checks s/c after a
//               programmable settle time and reports pass/fail results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa_self_test #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             x,
  output logic             y,
  output logic             z,
  input  logic             s,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       first_fail
);

  import fa_test_pkg::*;

  localparam logic [2:0] c_last_vec    = 3'(FA_NUM_VECTORS - 1);
  localparam logic [7:0] c_settle_load = 8'(SETTLE_CYCLES);

  fa_state_t        r_state;
  fa_state_t        w_next;
  logic [7:0]       r_settle;
  logic [2:0]       r_vec;
  logic [CNT_W-1:0] r_err;
  logic             r_fail_valid;
  logic [2:0]       r_first_fail;
  logic             r_pass;
  logic             w_mismatch;

  assign w_mismatch = ({c, s} != fa_expected(r_vec));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = SETTLE;
      end
      SETTLE: begin
        if (r_settle == 8'd1) w_next = CHECK;
      end
      CHECK: begin
        w_next = (r_vec == c_last_vec) ? FINISH : SETTLE;
      end
      FINISH: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // pass is resolved on the last CHECK so that it is visible alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle     <= 8'd0;
      r_vec        <= 3'd0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= 3'd0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_vec        <= 3'd0;
            r_settle     <= c_settle_load;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= 3'd0;
            r_pass       <= 1'b0;
          end
        end
        SETTLE: begin
          r_settle <= r_settle - 8'd1;
        end
        CHECK: begin
          if (w_mismatch) begin
            if (r_err != '1) r_err <= r_err + 1'b1;
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_first_fail <= r_vec;
            end
          end
          if (r_vec != c_last_vec) begin
            r_vec    <= r_vec + 3'd1;
            r_settle <= c_settle_load;
          end else begin
            r_pass <= !(r_fail_valid || w_mismatch);
          end
        end
        default: ;
      endcase
    end
  end

  assign x          = r_vec[2];
  assign y          = r_vec[1];
  assign z          = r_vec[0];
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_valid = r_fail_valid;
  assign first_fail = r_first_fail;

endmodule

`default_nettype wire

// File: tb/tb_fa_self_test.sv
// ============================================================================
// Module      : tb_fa_self_test
// Description : Self-checking bench for fa_self_test using a table-driven
//               adder response and an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fa_self_test;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Response table: the adder's {c,s} output for each input vector.
  logic [1:0] resp [8];

  // Instance A: S=2, CNT_W=4.  Instance B: S=1, CNT_W=2.
  logic       a_start, a_x, a_y, a_z, a_s, a_c, a_busy, a_done, a_pass, a_fv;
  logic [3:0] a_err;
  logic [2:0] a_ff;
  logic       b_start, b_x, b_y, b_z, b_s, b_c, b_busy, b_done, b_pass, b_fv;
  logic [1:0] b_err;
  logic [2:0] b_ff;

  assign a_s = resp[{a_x, a_y, a_z}][0];
  assign a_c = resp[{a_x, a_y, a_z}][1];
  assign b_s = resp[{b_x, b_y, b_z}][0];
  assign b_c = resp[{b_x, b_y, b_z}][1];

  fa_self_test #(.SETTLE_CYCLES(2), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start),
    .x(a_x), .y(a_y), .z(a_z), .s(a_s), .c(a_c),
    .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_count(a_err), .fail_valid(a_fv), .first_fail(a_ff)
  );

  fa_self_test #(.SETTLE_CYCLES(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start),
    .x(b_x), .y(b_y), .z(b_z), .s(b_s), .c(b_c),
    .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err), .fail_valid(b_fv), .first_fail(b_ff)
  );

  logic       sel = 1'b0;
  logic       o_busy, o_done, o_pass, o_fv;
  logic [2:0] o_vec, o_ff;
  logic [3:0] o_err;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_done = sel ? b_done : a_done;
  assign o_pass = sel ? b_pass : a_pass;
  assign o_fv   = sel ? b_fv   : a_fv;
  assign o_vec  = sel ? {b_x, b_y, b_z} : {a_x, a_y, a_z};
  assign o_ff   = sel ? b_ff   : a_ff;
  assign o_err  = sel ? {2'b00, b_err} : a_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit mism(input int k);
    logic [2:0] kv;
    kv = 3'(k);
    return resp[kv] != 2'($countones(kv));
  endfunction

  task automatic set_start(input logic v);
    a_start = sel ? 1'b0 : v;
    b_start = sel ? v : 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_pass"}, o_pass, 0);
    chk({tag, "_err"},  o_err,  0);
    chk({tag, "_fv"},   o_fv,   0);
    chk({tag, "_ff"},   o_ff,   0);
    chk({tag, "_xyz"},  o_vec,  0);
  endtask

  // One complete run on the selected instance, checked every cycle against the
  // timing rules: vector k applied from k(S+1)+1, checked at (k+1)(S+1),
  // results visible one cycle later, FINISH at 8(S+1)+1.
  task automatic run(input logic sel_i, input bit hold);
    int S, fin, maxc, ne, ff, dones;
    sel  = sel_i;
    S    = sel_i ? 1 : 2;
    maxc = sel_i ? 3 : 15;
    fin  = 8 * (S + 1) + 1;
    @(negedge clk);
    set_start(1'b1);
    for (int n = 1; n <= fin + 1; n++) begin
      @(negedge clk);
      if (!hold) set_start(1'b0);
      ne = 0;
      ff = 8;
      for (int k = 0; k < 8; k++) begin
        if (mism(k) && ((k + 1) * (S + 1) + 1 <= n)) begin
          ne++;
          if (ff == 8) ff = k;
        end
      end
      chk("busy", o_busy, n <= fin);
      chk("done", o_done, n == fin);
      chk("xyz",  o_vec,  (n > 8 * (S + 1)) ? 7 : (n - 1) / (S + 1));
      chk("err_count",  o_err, (ne > maxc) ? maxc : ne);
      chk("fail_valid", o_fv,  ne > 0);
      if (ne > 0) chk("first_fail", o_ff, ff);
      chk("pass", o_pass, (n >= fin) && (ne == 0));
    end
    if (hold) begin
      // start still high in the IDLE cycle after FINISH: a second run begins.
      @(negedge clk);
      set_start(1'b0);
      chk("rerun_busy", o_busy, 1);
      chk("rerun_err",  o_err,  0);
      chk("rerun_fv",   o_fv,   0);
      chk("rerun_pass", o_pass, 0);
      dones = 0;
      for (int m = fin + 2; m <= 2 * fin + 2; m++) begin
        if (o_done) begin
          dones++;
          chk("rerun_done_cycle", m, 2 * fin + 1);
        end
        @(negedge clk);
      end
      chk("rerun_done_count", dones, 1);
      chk("rerun_idle", o_busy, 0);
    end
  endtask

  task automatic table_correct();
    for (int k = 0; k < 8; k++) resp[k] = 2'($countones(3'(k)));
  endtask

  task automatic table_random();
    for (int k = 0; k < 8; k++)
      resp[k] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'($countones(3'(k)));
  endtask

  initial begin
    a_start = 1'b0;
    b_start = 1'b0;
    table_correct();
    repeat (2) @(negedge clk);
    sel = 1'b0; #1 check_all_zero("rst_a");
    sel = 1'b1; #1 check_all_zero("rst_b");
    @(negedge clk);
    rst_n = 1'b1;

    // Correct adder, S=2.
    run(1'b0, 1'b0);

    // s stuck at 0: vectors 1,2,4,7 fail.
    for (int k = 0; k < 8; k++) resp[k] = {($countones(3'(k)) >= 2), 1'b0};
    run(1'b0, 1'b0);
    chk("stuck_err", o_err, 4);
    chk("stuck_ff",  o_ff,  1);
    chk("stuck_pass", o_pass, 0);

    // c inverted on the 2-bit counter instance: saturates at 3.
    for (int k = 0; k < 8; k++) resp[k] = 2'($countones(3'(k))) ^ 2'b10;
    run(1'b1, 1'b0);
    chk("inv_err",  o_err, 3);
    chk("inv_ff",   o_ff,  0);
    chk("inv_pass", o_pass, 0);

    // start held high through the run, following a failing run.
    run(1'b0, 1'b1);

    // Reset while vector 4 is checked (S=1: cycle 10).
    table_correct();
    sel = 1'b1;
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    repeat (9) @(negedge clk);
    chk("pre_rst_xyz", o_vec, 4);
    rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b1, 1'b0);

    // Randomised adder faults on both instances with random idle gaps.
    for (int r = 0; r < 8; r++) begin
      table_random();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(1'(r % 2), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
